// File: rtl/bit_serializer_if.sv
// Word-in / bit-out handshake bundle between a word producer and bit_serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             w;
    logic             w_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, w, w_valid, frame_start, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, w, w_valid, frame_start, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per Clk out on w.
// A one-word holding buffer lets consecutive words stream without a bubble.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input logic            Clk,
    input logic            Rst,
    bit_serializer_if.slave bus
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
    localparam logic [3:0]      GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;

    state_t           state;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] buf_data;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             buf_full;

    logic             accept, at_last, gap_done, load_pt;
    logic             load_buf, load_din, buf_wr, buf_full_n;
    logic [WIDTH-1:0] load_word, shifted;

    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    assign bus.din_ready = ~buf_full;
    assign accept        = bus.din_valid & ~buf_full;
    assign at_last       = (state == SHIFT) && (bit_cnt == LAST);
    assign gap_done      = (state == GAPS) && (gap_cnt == GAP_LAST);

    // Load points: idle, or the last bit when no gap follows. The buffer wins; an empty
    // buffer lets a word accepted this very cycle go straight to the shifter.
    assign load_pt    = (state == IDLE) || (at_last && (GAP == 0));
    assign load_buf   = buf_full && (load_pt || gap_done);
    assign load_din   = accept && load_pt;
    assign buf_wr     = accept && !load_din;
    assign buf_full_n = buf_wr | (buf_full & ~load_buf);
    assign load_word  = load_buf ? buf_data : bus.din;
    assign shifted    = (MSB_FIRST != 0) ? (shifter << 1) : (shifter >> 1);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state           <= IDLE;
            shifter         <= '0;
            buf_data        <= '0;
            bit_cnt         <= '0;
            gap_cnt         <= '0;
            buf_full        <= 1'b0;
            bus.w           <= 1'b0;
            bus.w_valid     <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            buf_full <= buf_full_n;
            if (buf_wr)
                buf_data <= bus.din;

            if (load_buf || load_din) begin
                state           <= SHIFT;
                shifter         <= load_word;
                bit_cnt         <= '0;
                bus.w           <= first_bit(load_word);
                bus.w_valid     <= 1'b1;
                bus.frame_start <= 1'b1;
                bus.busy        <= 1'b1;
            end else begin
                case (state)
                    SHIFT: begin
                        bus.frame_start <= 1'b0;
                        if (at_last) begin
                            bus.w       <= 1'b0;
                            bus.w_valid <= 1'b0;
                            if (GAP > 0) begin
                                state    <= GAPS;
                                gap_cnt  <= '0;
                                bus.busy <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                bus.busy <= buf_full_n;
                            end
                        end else begin
                            shifter  <= shifted;
                            bit_cnt  <= bit_cnt + 1'b1;
                            bus.w    <= first_bit(shifted);
                            bus.busy <= 1'b1;
                        end
                    end
                    GAPS: begin
                        if (gap_done) begin
                            state    <= IDLE;
                            bus.busy <= buf_full_n;
                        end else begin
                            gap_cnt  <= gap_cnt + 1'b1;
                        end
                    end
                    default: begin
                        bus.busy <= buf_full_n;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboarded bench for bit_serializer: three configurations, directed words, 1001 detector.
module tb_bit_serializer;
    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    bit_serializer_if #(.WIDTH(8)) ifa ();
    bit_serializer_if #(.WIDTH(8)) ifb ();
    bit_serializer_if #(.WIDTH(8)) ifc ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) dut_a (.Clk(Clk), .Rst(Rst), .bus(ifa));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) dut_b (.Clk(Clk), .Rst(Rst), .bus(ifb));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(2)) dut_c (.Clk(Clk), .Rst(Rst), .bus(ifc));

    // 1001 pattern detector fed by dut_a, advancing only on qualified bits
    logic [3:0] hist;
    logic       z;
    always @(posedge Clk or posedge Rst) begin
        if (Rst)               hist <= 4'd0;
        else if (ifa.w_valid)  hist <= {hist[2:0], ifa.w};
    end
    assign z = (hist == 4'b1001);

    typedef struct {
        logic w;
        logic fs;
        int   cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   nchk  = 0;
    int   nfail = 0;

    task automatic check(input string nm, input int act, input int req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // seq[7] is the first bit expected on the wire
    task automatic push(input int d, input logic [7:0] seq, input int start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.w   = seq[7-i];
            e.fs  = (i == 0);
            e.cyc = start + i;
            case (d)
                0:       qa.push_back(e);
                1:       qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
    endtask

    task automatic mon(input int d, input logic wv, input logic wb, input logic fs);
        exp_t e;
        bit   got;
        got = 1'b0;
        nchk++;
        if (wv) begin
            case (d)
                0:       if (qa.size() > 0) begin e = qa.pop_front(); got = 1'b1; end
                1:       if (qb.size() > 0) begin e = qb.pop_front(); got = 1'b1; end
                default: if (qc.size() > 0) begin e = qc.pop_front(); got = 1'b1; end
            endcase
            if (!got) begin
                nfail++;
                $display("FAIL spurious_bit dut%0d: w_valid=1 w=%b at cycle %0d, required no bit", d, wb, cyc);
            end else if (wb !== e.w || fs !== e.fs || cyc != e.cyc) begin
                nfail++;
                $display("FAIL bit dut%0d: got w=%b fs=%b cycle=%0d, required w=%b fs=%b cycle=%0d",
                         d, wb, fs, cyc, e.w, e.fs, e.cyc);
            end
        end else if (wb !== 1'b0 || fs !== 1'b0) begin
            nfail++;
            $display("FAIL idle_out dut%0d: got w=%b fs=%b with w_valid=0, required 0 0", d, wb, fs);
        end
    endtask

    task automatic drive(input int d, input logic [7:0] v, input logic vl);
        case (d)
            0:       begin ifa.din = v; ifa.din_valid = vl; end
            1:       begin ifb.din = v; ifb.din_valid = vl; end
            default: begin ifc.din = v; ifc.din_valid = vl; end
        endcase
    endtask

    function automatic logic rdy(input int d);
        case (d)
            0:       return ifa.din_ready;
            1:       return ifb.din_ready;
            default: return ifc.din_ready;
        endcase
    endfunction

    function automatic logic [4:0] outs(input int d);
        case (d)
            0:       return {ifa.w, ifa.w_valid, ifa.frame_start, ifa.busy, ifa.din_ready};
            1:       return {ifb.w, ifb.w_valid, ifb.frame_start, ifb.busy, ifb.din_ready};
            default: return {ifc.w, ifc.w_valid, ifc.frame_start, ifc.busy, ifc.din_ready};
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the handshake edge with hs = cyc of bit 0.
    task automatic send(input int d, input logic [7:0] word, output int hs);
        logic r;
        hs = -1;
        drive(d, word, 1'b1);
        for (int t = 0; t < 50; t++) begin
            r = rdy(d);
            @(posedge Clk); #1;
            if (r) begin
                hs = cyc;
                break;
            end
        end
        if (hs < 0) begin
            nchk++;
            nfail++;
            $display("FAIL handshake dut%0d: din_ready never seen, required a handshake within 50 cycles", d);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && (qa.size() + qb.size() + qc.size()) > 0; t++) @(posedge Clk);
        #1;
        check("drain_left", qa.size() + qb.size() + qc.size(), 0);
        repeat (3) @(posedge Clk);
        #1;
        check("idle_after", {outs(0), outs(1), outs(2)}, {5'b00001, 5'b00001, 5'b00001});
    endtask

    initial begin
        int         h, h2;
        logic [8:0] zexp;

        fork
            forever begin
                @(negedge Clk);
                mon(0, ifa.w_valid, ifa.w, ifa.frame_start);
                mon(1, ifb.w_valid, ifb.w, ifb.frame_start);
                mon(2, ifc.w_valid, ifc.w, ifc.frame_start);
            end
        join_none

        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);
        Rst = 1'b0;
        #1 Rst = 1'b1;
        #2;
        check("reset_a", outs(0), 5'b00001);
        check("reset_b", outs(1), 5'b00001);
        check("reset_c", outs(2), 5'b00001);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk); #1;

        // one-shot MSB-first B3
        send(0, 8'hB3, h);
        push(0, 8'hB3, h, 8);
        drive(0, 8'h00, 1'b0);
        drain();

        // back-to-back B3, 1C through the buffer
        send(0, 8'hB3, h);
        push(0, 8'hB3, h, 8);
        send(0, 8'h1C, h2);
        check("t2_second_hs", h2, h + 1);
        push(0, 8'h1C, h + 8, 8);
        check("t2_ready_low", ifa.din_ready, 0);
        drive(0, 8'hFF, 1'b0);
        for (int t = 0; t < 20 && cyc < h + 8; t++) begin @(posedge Clk); #1; end
        check("t2_ready_back", ifa.din_ready, 1);
        drain();

        // LSB-first 01, then 80 offered exactly on the last bit (bypass load)
        send(1, 8'h01, h);
        push(1, 8'b1000_0000, h, 8);
        drive(1, 8'h00, 1'b0);
        for (int t = 0; t < 20 && cyc < h + 7; t++) begin @(posedge Clk); #1; end
        send(1, 8'h80, h2);
        check("t3_bypass_hs", h2, h + 8);
        push(1, 8'b0000_0001, h + 8, 8);
        drive(1, 8'h00, 1'b0);
        drain();

        // GAP=2: A5 then 3C with two idle cycles between
        send(2, 8'hA5, h);
        push(2, 8'hA5, h, 8);
        send(2, 8'h3C, h2);
        push(2, 8'h3C, h + 10, 8);
        drive(2, 8'h00, 1'b0);
        for (int t = 0; t < 20 && cyc < h + 8; t++) begin @(posedge Clk); #1; end
        check("t4_gap_busy", {ifc.busy, ifc.w_valid}, 2'b10);
        drain();

        // async reset at bit 4 of FF
        send(0, 8'hFF, h);
        push(0, 8'hFF, h, 4);
        drive(0, 8'h00, 1'b0);
        for (int t = 0; t < 20 && cyc < h + 4; t++) begin @(posedge Clk); #1; end
        check("t5_midword", ifa.w_valid, 1);
        #1 Rst = 1'b1;
        #1;
        check("t5_async_rst", outs(0), 5'b00001);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk); #1;
        repeat (10) @(posedge Clk);
        #1;
        check("t5_no_resume", {ifa.w_valid, ifa.busy}, 2'b00);
        drain();

        // 90 through the 1001 detector: z only after the 4th bit
        send(0, 8'h90, h);
        push(0, 8'h90, h, 8);
        drive(0, 8'h00, 1'b0);
        zexp = 9'b0_0001_0000;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("t6_z_k%0d", k), z, zexp[k]);
            @(posedge Clk); #1;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
